// File: rtl/imem_boot_loader.sv
// Boot loader that turns a framed byte stream into instruction-memory word writes.
// It holds the core in reset until the whole image has arrived and its XOR checksum matches.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR      = 32'h0,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        restart,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        error
);
    localparam int IDX_W = $clog2(DEPTH_WORDS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] ST_HDR0  = 3'd0;
    localparam logic [2:0] ST_HDR1  = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;
    localparam logic [2:0] ST_ERROR = 3'd6;

    logic [2:0]       state_reg, state_next;
    logic [15:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [1:0]       byte_idx_reg, byte_idx_next;
    logic [7:0]       csum_reg, csum_next;
    logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
    logic             we_reg, we_next;
    logic [31:0]      addr_reg, addr_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             done_reg, done_next;
    logic             error_reg, error_next;
    logic             core_rst_n_reg, core_rst_n_next;

    logic             accept;
    logic             timing_state;
    logic [TO_W-1:0]  to_cnt_inc;
    logic [31:0]      hdr_cnt;

    assign rx_ready = rst && ((state_reg == ST_HDR0) || (state_reg == ST_HDR1) ||
                              (state_reg == ST_DATA) || (state_reg == ST_CSUM));
    assign accept       = rx_valid && rx_ready;
    assign timing_state = (state_reg == ST_HDR1) || (state_reg == ST_DATA) ||
                          (state_reg == ST_WRITE) || (state_reg == ST_CSUM);
    assign to_cnt_inc   = to_cnt_reg + 1'b1;
    assign hdr_cnt      = 32'({rx_data, cnt_reg[7:0]});

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        idx_next        = idx_reg;
        byte_idx_next   = byte_idx_reg;
        csum_next       = csum_reg;
        to_cnt_next     = to_cnt_reg;
        we_next         = 1'b0;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        done_next       = done_reg;
        error_next      = error_reg;
        core_rst_n_next = core_rst_n_reg;

        if (timing_state) begin
            to_cnt_next = accept ? '0 : to_cnt_inc;
        end

        case (state_reg)
            ST_HDR0: begin
                to_cnt_next = '0;
                if (accept) begin
                    cnt_next[7:0] = rx_data;
                    csum_next     = csum_reg ^ rx_data;
                    state_next    = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (accept) begin
                    cnt_next[15:8] = rx_data;
                    csum_next      = csum_reg ^ rx_data;
                    byte_idx_next  = 2'd0;
                    if (hdr_cnt > 32'(DEPTH_WORDS)) begin
                        state_next = ST_ERROR;
                        error_next = 1'b1;
                    end else if (hdr_cnt == 32'd0) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wdata_next[{byte_idx_reg, 3'b000} +: 8] = rx_data;
                    csum_next     = csum_reg ^ rx_data;
                    byte_idx_next = byte_idx_reg + 2'd1;
                    if (byte_idx_reg == 2'd3) begin
                        // Strobe and address are registered so they line up with the WRITE state.
                        we_next    = 1'b1;
                        addr_next  = BASE_ADDR + (32'(idx_reg) << 2);
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                idx_next = idx_reg + 1'b1;
                if (32'(idx_reg) + 32'd1 == 32'(cnt_reg)) begin
                    state_next = ST_CSUM;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (rx_data == csum_reg) begin
                        state_next      = ST_DONE;
                        done_next       = 1'b1;
                        core_rst_n_next = 1'b1;
                    end else begin
                        state_next = ST_ERROR;
                        error_next = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERROR: begin
                if (restart) begin
                    state_next      = ST_HDR0;
                    done_next       = 1'b0;
                    error_next      = 1'b0;
                    csum_next       = 8'h00;
                    idx_next        = '0;
                    byte_idx_next   = 2'd0;
                    to_cnt_next     = '0;
                    core_rst_n_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_HDR0;
            end
        endcase

        // A byte arriving in the same cycle always beats the timeout.
        if (timing_state && !accept && (to_cnt_inc == TO_W'(TIMEOUT_CYCLES))) begin
            state_next      = ST_ERROR;
            error_next      = 1'b1;
            we_next         = 1'b0;
            core_rst_n_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_HDR0;
            cnt_reg        <= '0;
            idx_reg        <= '0;
            byte_idx_reg   <= 2'd0;
            csum_reg       <= 8'h00;
            to_cnt_reg     <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= 32'h0;
            wdata_reg      <= 32'h0;
            done_reg       <= 1'b0;
            error_reg      <= 1'b0;
            core_rst_n_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            byte_idx_reg   <= byte_idx_next;
            csum_reg       <= csum_next;
            to_cnt_reg     <= to_cnt_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            done_reg       <= done_next;
            error_reg      <= error_next;
            core_rst_n_reg <= core_rst_n_next;
        end
    end

    assign imem_we    = we_reg;
    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;
    assign done       = done_reg;
    assign error      = error_reg;
    assign core_rst_n = core_rst_n_reg;

endmodule
